// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and SCLK edge-select helpers.
// Used by spi_slave and spi_master.
`timescale 1ns/1ps
package spi_pkg;

    // Frame FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_t;

    // Which synchronized SCLK transition an action is tied to
    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } edge_sel_t;

    // Leading edge leaves the CPOL level. CPHA=0 samples on the leading edge,
    // CPHA=1 on the trailing edge, so sampling is on SCLK rise when CPOL==CPHA.
    function automatic edge_sel_t sample_edge_sel(input logic cpol, input logic cpha);
        return (cpol == cpha) ? EDGE_RISE : EDGE_FALL;
    endfunction

    // The shift (drive) edge is always the opposite transition
    function automatic edge_sel_t shift_edge_sel(input logic cpol, input logic cpha);
        return (cpol == cpha) ? EDGE_FALL : EDGE_RISE;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus a change detector
// on the synchronized copy. Rise/fall are derived by the user from
// sync_q and changed (rise = changed & sync_q, fall = changed & ~sync_q).
`timescale 1ns/1ps
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic sync_q,
    output logic changed
);

    logic [STAGES-1:0] pipe;
    logic              prev;

    // Synchronizer chain and one-clk-delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe <= {STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            pipe <= {pipe[STAGES-2:0], din};
            prev <= pipe[STAGES-1];
        end
    end

    assign sync_q  = pipe[STAGES-1];
    assign changed = pipe[STAGES-1] ^ prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, MSB first, oversampled by the system clock
// (clk must be at least 8x SCLK). One-word tx buffer with valid/ready,
// one-clk rx_valid pulse per received word, back-to-back words per frame.
// Optional macro SPI_SLAVE_ERR_EN adds tx_underrun and frame_err pulses.
`timescale 1ns/1ps
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
`ifdef SPI_SLAVE_ERR_EN
    ,
    output logic                  tx_underrun,
    output logic                  frame_err
`endif
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

    spi_state_t            state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  cpol_q;
    logic                  cpha_q;

    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  buf_full;

    logic                  sclk_s;
    logic                  sclk_chg;
    logic                  cs_s;
    logic                  cs_chg;
    logic [STAGES-1:0]     mosi_pipe;
    logic                  mosi_s;

    logic                  sclk_rise;
    logic                  sclk_fall;
    logic                  cs_fall;
    logic                  sample_edge;
    logic                  shift_edge;
    logic                  consume;
    logic [DATA_WIDTH-1:0] load_word;

    spi_sync_edge #(
        .STAGES    (STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (SCLK),
        .sync_q  (sclk_s),
        .changed (sclk_chg)
    );

    spi_sync_edge #(
        .STAGES    (STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (CS),
        .sync_q  (cs_s),
        .changed (cs_chg)
    );

    // MOSI synchronizer, same depth as SCLK so data and clock stay aligned
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mosi_pipe <= '0;
        end else begin
            mosi_pipe <= {mosi_pipe[STAGES-2:0], MOSI};
        end
    end

    assign mosi_s    = mosi_pipe[STAGES-1];
    assign sclk_rise = sclk_chg & sclk_s;
    assign sclk_fall = sclk_chg & ~sclk_s;
    assign cs_fall   = cs_chg & ~cs_s;

    assign sample_edge = (sample_edge_sel(cpol_q, cpha_q) == EDGE_RISE) ? sclk_rise : sclk_fall;
    assign shift_edge  = (shift_edge_sel(cpol_q, cpha_q) == EDGE_RISE) ? sclk_rise : sclk_fall;

    // LOAD only consumes the buffer when the frame is still active
    assign consume   = (state == ST_LOAD) && !cs_s;
    assign load_word = buf_full ? tx_buf : '0;
    assign tx_ready  = ~buf_full;

    // One-word tx buffer; a handshake can only happen while empty, so a
    // same-clk LOAD has already taken the old (empty) contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_buf   <= '0;
            buf_full <= 1'b0;
        end else if (tx_valid && !buf_full) begin
            tx_buf   <= tx_data;
            buf_full <= 1'b1;
        end else if (consume) begin
            buf_full <= 1'b0;
        end
    end

    // Frame FSM with shift registers, bit counter and registered outputs.
    // A shift edge before the first sample of a word is ignored: for CPHA=1
    // the MSB is already on MISO, and for CPHA=0 it is the trailing edge of
    // the previous word's last bit arriving after the next LOAD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            bit_cnt   <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            MISO      <= 1'b0;
            miso_oe   <= 1'b0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
`ifdef SPI_SLAVE_ERR_EN
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            miso_oe  <= ~cs_s;
`ifdef SPI_SLAVE_ERR_EN
            tx_underrun <= 1'b0;
            frame_err   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    MISO    <= 1'b0;
                    busy    <= 1'b0;
                    if (cs_fall) begin
                        cpol_q <= CPOL;
                        cpha_q <= CPHA;
                        busy   <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    bit_cnt <= '0;
                    if (cs_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        MISO  <= 1'b0;
                    end else begin
                        shift_reg <= load_word;
                        MISO      <= load_word[DATA_WIDTH-1];
                        state     <= ST_SHIFT;
`ifdef SPI_SLAVE_ERR_EN
                        tx_underrun <= ~buf_full;
`endif
                    end
                end

                ST_SHIFT: begin
                    if (bit_cnt == CNT_FULL) begin
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                        bit_cnt  <= '0;
                        if (cs_s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            MISO  <= 1'b0;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end else if (cs_s) begin
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        MISO    <= 1'b0;
                        bit_cnt <= '0;
`ifdef SPI_SLAVE_ERR_EN
                        frame_err <= (bit_cnt != '0);
`endif
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                        if (shift_edge && (bit_cnt != '0)) begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                            MISO      <= shift_reg[DATA_WIDTH-2];
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    MISO  <= 1'b0;
                end
            endcase
        end
    end

endmodule
